// File: rtl/xosera_host_bus_pkg.sv
// Shared types and constants for the Xosera host bus initiator.
package xv;

  localparam int unsigned HB_CNT_W  = 4;
  localparam int unsigned HB_REG_W  = 4;
  localparam int unsigned HB_BYTE_W = 8;
  localparam int unsigned HB_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } hb_state_t;

  localparam logic [1:0] HB_EVEN = 2'b10;
  localparam logic [1:0] HB_ODD  = 2'b01;

  typedef struct packed {
    logic                 rd_nwr;
    logic [HB_REG_W-1:0]  reg_num;
    logic [1:0]           bytes;
    logic [HB_DATA_W-1:0] data;
  } hb_req_t;

  // Selects the byte of a 16-bit word presented on the bus; even byte is [15:8].
  function automatic logic [HB_BYTE_W-1:0] hb_byte(input logic [HB_DATA_W-1:0] word,
                                                    input logic                 odd);
    return odd ? word[7:0] : word[15:8];
  endfunction

endpackage

// File: rtl/xosera_host_bus_if.sv
// Host-side request/response channel of the Xosera bus initiator.
interface xosera_host_bus_if;

  logic                     req_valid_i;
  logic                     req_ready_o;
  logic                     req_rd_nwr_i;
  logic [xv::HB_REG_W-1:0]  req_reg_num_i;
  logic [1:0]               req_bytes_i;
  logic [xv::HB_DATA_W-1:0] req_data_i;
  logic                     rsp_valid_o;
  logic [xv::HB_DATA_W-1:0] rsp_data_o;

  modport master (
    output req_valid_i, req_rd_nwr_i, req_reg_num_i, req_bytes_i, req_data_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o
  );

  modport slave (
    input  req_valid_i, req_rd_nwr_i, req_reg_num_i, req_bytes_i, req_data_i,
    output req_ready_o, rsp_valid_o, rsp_data_o
  );

endinterface

// File: rtl/xosera_host_bus_intr_sync.sv
// Two-flop synchroniser for bus_intr with a one-cycle rising-edge pulse.
module intr_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic intr_i,
  output logic pulse_o
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic s3_q, s3_d;
  logic pulse_q, pulse_d;

  always_comb begin
    s1_d    = intr_i;
    s2_d    = s1_q;
    s3_d    = s2_q;
    pulse_d = s2_q & ~s3_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      s3_q    <= s3_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/xosera_host_bus.sv
// Xosera 8-bit register bus initiator: splits 16-bit requests into timed byte strobes.
module xosera_host_bus
  import xv::*;
#(
  parameter int unsigned SETUP_CYCLES  = 1,
  parameter int unsigned STROBE_CYCLES = 2,
  parameter int unsigned HOLD_CYCLES   = 1
) (
  input  logic                 clk,
  input  logic                 reset_n_i,
  xosera_host_bus_if.slave     host,
  output logic                 bus_cs_n_o,
  output logic                 bus_rd_nwr_o,
  output logic [HB_REG_W-1:0]  bus_reg_num_o,
  output logic                 bus_bytesel_o,
  output logic [HB_BYTE_W-1:0] bus_data_o,
  output logic                 bus_data_oe_o,
  input  logic [HB_BYTE_W-1:0] bus_data_i,
  input  logic                 bus_intr_i,
  output logic                 intr_o
);

  localparam logic [HB_CNT_W-1:0] SETUP_LOAD  = HB_CNT_W'(SETUP_CYCLES - 1);
  localparam logic [HB_CNT_W-1:0] STROBE_LOAD = HB_CNT_W'(STROBE_CYCLES - 1);
  localparam logic [HB_CNT_W-1:0] HOLD_LOAD   = HB_CNT_W'(HOLD_CYCLES - 1);

  hb_state_t            state_q, state_d;
  logic [HB_CNT_W-1:0]  cnt_q, cnt_d;
  hb_req_t              req_q, req_d;
  logic [HB_DATA_W-1:0] acc_q, acc_d;
  logic                 cs_n_q, cs_n_d;
  logic                 rd_nwr_q, rd_nwr_d;
  logic [HB_REG_W-1:0]  reg_num_q, reg_num_d;
  logic                 bytesel_q, bytesel_d;
  logic [HB_BYTE_W-1:0] data_q, data_d;
  logic                 oe_q, oe_d;
  logic                 ready_q, ready_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [HB_DATA_W-1:0] rsp_data_q, rsp_data_d;

  // Bus outputs are computed from the next state so they line up with the phase.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    acc_d       = acc_q;
    cs_n_d      = 1'b1;
    rd_nwr_d    = rd_nwr_q;
    reg_num_d   = reg_num_q;
    bytesel_d   = bytesel_q;
    data_d      = data_q;
    oe_d        = oe_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;

    unique case (state_q)
      IDLE: begin
        if (host.req_valid_i) begin
          req_d.rd_nwr  = host.req_rd_nwr_i;
          req_d.reg_num = host.req_reg_num_i;
          req_d.bytes   = host.req_bytes_i;
          req_d.data    = host.req_data_i;
          acc_d         = '0;
          if (host.req_bytes_i == 2'b00) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = '0;
          end else begin
            state_d   = SETUP;
            cnt_d     = SETUP_LOAD;
            rd_nwr_d  = host.req_rd_nwr_i;
            reg_num_d = host.req_reg_num_i;
            bytesel_d = ~|(host.req_bytes_i & HB_EVEN);
            oe_d      = ~host.req_rd_nwr_i;
            if (!host.req_rd_nwr_i) begin
              data_d = hb_byte(host.req_data_i, ~|(host.req_bytes_i & HB_EVEN));
            end
          end
        end
      end

      SETUP: begin
        if (cnt_q == '0) begin
          state_d = STROBE;
          cnt_d   = STROBE_LOAD;
          cs_n_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      STROBE: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          cnt_d   = HOLD_LOAD;
          if (req_q.rd_nwr) begin
            if (bytesel_q) acc_d[7:0]  = bus_data_i;
            else           acc_d[15:8] = bus_data_i;
          end
        end else begin
          cnt_d  = cnt_q - 1'b1;
          cs_n_d = 1'b0;
        end
      end

      HOLD: begin
        if (cnt_q == '0) begin
          if (!bytesel_q && |(req_q.bytes & HB_ODD)) begin
            state_d   = SETUP;
            cnt_d     = SETUP_LOAD;
            bytesel_d = 1'b1;
            if (!req_q.rd_nwr) data_d = hb_byte(req_q.data, 1'b1);
          end else begin
            state_d     = IDLE;
            oe_d        = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_data_d  = acc_q;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    endcase

    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_q       <= '0;
      acc_q       <= '0;
      cs_n_q      <= 1'b1;
      rd_nwr_q    <= 1'b1;
      reg_num_q   <= '0;
      bytesel_q   <= 1'b0;
      data_q      <= '0;
      oe_q        <= 1'b0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      acc_q       <= acc_d;
      cs_n_q      <= cs_n_d;
      rd_nwr_q    <= rd_nwr_d;
      reg_num_q   <= reg_num_d;
      bytesel_q   <= bytesel_d;
      data_q      <= data_d;
      oe_q        <= oe_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  intr_sync u_intr_sync (
    .clk     (clk),
    .rst_n   (reset_n_i),
    .intr_i  (bus_intr_i),
    .pulse_o (intr_o)
  );

  assign bus_cs_n_o       = cs_n_q;
  assign bus_rd_nwr_o     = rd_nwr_q;
  assign bus_reg_num_o    = reg_num_q;
  assign bus_bytesel_o    = bytesel_q;
  assign bus_data_o       = data_q;
  assign bus_data_oe_o    = oe_q;
  assign host.req_ready_o = ready_q;
  assign host.rsp_valid_o = rsp_valid_q;
  assign host.rsp_data_o  = rsp_data_q;

endmodule

// File: tb/tb_xosera_host_bus.sv
// Scoreboard bench for xosera_host_bus: strobes, responses and interrupt pulses.
module tb_xosera_host_bus;
  import xv::*;

  localparam int S = 1;
  localparam int W = 2;
  localparam int H = 1;
  localparam int BYTE_CYC = S + W + H;

  logic       clk = 1'b0;
  logic       reset_n_i = 1'b0;
  logic       bus_cs_n_o, bus_rd_nwr_o, bus_bytesel_o, bus_data_oe_o;
  logic [3:0] bus_reg_num_o;
  logic [7:0] bus_data_o, bus_data_i;
  logic       bus_intr_i = 1'b0;
  logic       intr_o;

  xosera_host_bus_if hif();

  xosera_host_bus #(.SETUP_CYCLES(S), .STROBE_CYCLES(W), .HOLD_CYCLES(H)) dut (
    .clk           (clk),
    .reset_n_i     (reset_n_i),
    .host          (hif.slave),
    .bus_cs_n_o    (bus_cs_n_o),
    .bus_rd_nwr_o  (bus_rd_nwr_o),
    .bus_reg_num_o (bus_reg_num_o),
    .bus_bytesel_o (bus_bytesel_o),
    .bus_data_o    (bus_data_o),
    .bus_data_oe_o (bus_data_oe_o),
    .bus_data_i    (bus_data_i),
    .bus_intr_i    (bus_intr_i),
    .intr_o        (intr_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic       bytesel;
    logic       rd;
    logic [3:0] reg_num;
    logic [7:0] data;
  } strobe_t;

  typedef struct {
    int          cyc;
    logic [15:0] data;
  } rsp_t;

  strobe_t sq[$];
  rsp_t    rq[$];
  int      iq[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_acc = -1;
  int last_rsp = -1;
  int n_falls = 0;
  int cs_run = 0;
  int last_rise = -1;
  logic prev_cs = 1'b1;

  logic [7:0] model_even = 8'h00;
  logic [7:0] model_odd  = 8'h00;

  // Xosera read model: drives data only while selected for a read.
  assign bus_data_i = (!bus_cs_n_o && bus_rd_nwr_o) ? (bus_bytesel_o ? model_odd : model_even) : 8'hEE;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pushes expectations on accept, checks bus strobes, responses and interrupts.
  always @(negedge clk) begin
    if (!reset_n_i) begin
      prev_cs   = 1'b1;
      cs_run    = 0;
      last_rise = -1;
    end else begin
      if (hif.req_valid_i && hif.req_ready_o) begin
        automatic rsp_t    r;
        automatic strobe_t s;
        automatic int      k = 0;
        automatic int      nb = int'(hif.req_bytes_i[1]) + int'(hif.req_bytes_i[0]);
        r.cyc  = cyc + 1 + nb * BYTE_CYC;
        r.data = hif.req_rd_nwr_i ? {hif.req_bytes_i[1] ? model_even : 8'h00,
                                     hif.req_bytes_i[0] ? model_odd  : 8'h00} : 16'h0000;
        rq.push_back(r);
        if (hif.req_bytes_i[1]) begin
          s.cyc = cyc + 1 + S; s.bytesel = 1'b0; s.rd = hif.req_rd_nwr_i;
          s.reg_num = hif.req_reg_num_i;
          s.data = hif.req_rd_nwr_i ? 8'h00 : hif.req_data_i[15:8];
          sq.push_back(s);
          k = 1;
        end
        if (hif.req_bytes_i[0]) begin
          s.cyc = cyc + 1 + k * BYTE_CYC + S; s.bytesel = 1'b1; s.rd = hif.req_rd_nwr_i;
          s.reg_num = hif.req_reg_num_i;
          s.data = hif.req_rd_nwr_i ? 8'h00 : hif.req_data_i[7:0];
          sq.push_back(s);
        end
        last_acc = cyc;
      end

      n_cmp++;
      if (bus_rd_nwr_o && bus_data_oe_o) begin
        n_err++;
        $display("FAIL oe_on_read: cyc %0d oe=%b rd_nwr=%b, required oe=0", cyc, bus_data_oe_o, bus_rd_nwr_o);
      end

      if (!bus_cs_n_o) begin
        if (prev_cs) begin
          n_falls++;
          n_cmp++;
          if (sq.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_strobe: cyc %0d, required none", cyc);
          end else begin
            automatic strobe_t e = sq.pop_front();
            automatic logic [46:0] obs = {32'(cyc), bus_bytesel_o, bus_rd_nwr_o, bus_reg_num_o,
                                          bus_data_oe_o, bus_rd_nwr_o ? 8'h00 : bus_data_o};
            automatic logic [46:0] exp = {32'(e.cyc), e.bytesel, e.rd, e.reg_num, ~e.rd, e.data};
            if (obs !== exp) begin
              n_err++;
              $display("FAIL strobe: got cyc=%0d sel=%b rd=%b reg=%h oe=%b data=%h, required cyc=%0d sel=%b rd=%b reg=%h oe=%b data=%h",
                       cyc, bus_bytesel_o, bus_rd_nwr_o, bus_reg_num_o, bus_data_oe_o, bus_data_o,
                       e.cyc, e.bytesel, e.rd, e.reg_num, ~e.rd, e.data);
            end
          end
          if (last_rise >= 0) begin
            n_cmp++;
            if (cyc - last_rise < H + S) begin
              n_err++;
              $display("FAIL cs_high_gap: got %0d cycles, required >= %0d", cyc - last_rise, H + S);
            end
          end
        end
        cs_run++;
      end else if (!prev_cs) begin
        n_cmp++;
        if (cs_run !== W) begin
          n_err++;
          $display("FAIL cs_low_len: got %0d cycles, required %0d", cs_run, W);
        end
        cs_run    = 0;
        last_rise = cyc;
      end
      prev_cs = bus_cs_n_o;

      if (hif.rsp_valid_o) begin
        n_cmp++;
        last_rsp = cyc;
        if (rq.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_rsp: cyc %0d data=%h, required none", cyc, hif.rsp_data_o);
        end else begin
          automatic rsp_t e = rq.pop_front();
          if (cyc !== e.cyc || hif.rsp_data_o !== e.data) begin
            n_err++;
            $display("FAIL rsp: got cyc=%0d data=%h, required cyc=%0d data=%h",
                     cyc, hif.rsp_data_o, e.cyc, e.data);
          end
        end
      end

      if (intr_o) begin
        n_cmp++;
        if (iq.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_intr: cyc %0d, required none", cyc);
        end else begin
          automatic int e = iq.pop_front();
          if (cyc !== e) begin
            n_err++;
            $display("FAIL intr_latency: got cyc=%0d, required cyc=%0d", cyc, e);
          end
        end
      end
    end
  end

  task automatic drive_req(input logic rd, input logic [3:0] rn, input logic [1:0] bytes,
                           input logic [15:0] data, input bit keep_valid, output int acc_cyc);
    bit ok = 0;
    @(posedge clk); #1;
    hif.req_rd_nwr_i  = rd;
    hif.req_reg_num_i = rn;
    hif.req_bytes_i   = bytes;
    hif.req_data_i    = data;
    hif.req_valid_i   = 1'b1;
    acc_cyc = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (hif.req_ready_o) begin ok = 1; acc_cyc = cyc; break; end
    end
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL accept_timeout: ready stayed 0, required 1 within 200 cycles");
    end
    if (!keep_valid) begin
      @(posedge clk); #1;
      hif.req_valid_i = 1'b0;
    end
  endtask

  task automatic wait_drain();
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rq.size() == 0 && sq.size() == 0) begin ok = 1; break; end
    end
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout: %0d rsp / %0d strobes pending, required 0", rq.size(), sq.size());
    end
    repeat (3) @(negedge clk);
  endtask

  function automatic logic [35:0] out_vec();
    return {bus_cs_n_o, bus_rd_nwr_o, bus_reg_num_o, bus_bytesel_o, bus_data_o, bus_data_oe_o,
            hif.rsp_valid_o, hif.rsp_data_o, intr_o, hif.req_ready_o};
  endfunction

  localparam logic [35:0] RESET_VEC = {1'b1, 1'b1, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1};

  task automatic test_reset();
    int a;
    bit ok = 0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (out_vec() !== RESET_VEC) begin
      n_err++;
      $display("FAIL reset_values: got %h, required %h", out_vec(), RESET_VEC);
    end
    reset_n_i = 1'b1;
    drive_req(1'b0, 4'h7, 2'b11, 16'h1357, 1'b0, a);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bus_cs_n_o) begin ok = 1; break; end
    end
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL reset_no_strobe: cs_n stayed 1, required a strobe");
    end
    #2 reset_n_i = 1'b0;
    #1;
    n_cmp++;
    if (bus_cs_n_o !== 1'b1) begin
      n_err++;
      $display("FAIL reset_async_cs: got cs_n=%b, required 1", bus_cs_n_o);
    end
    n_cmp++;
    if (out_vec() !== RESET_VEC) begin
      n_err++;
      $display("FAIL reset_async_values: got %h, required %h", out_vec(), RESET_VEC);
    end
    rq.delete();
    sq.delete();
    repeat (4) @(negedge clk);
    reset_n_i = 1'b1;
    repeat (12) @(negedge clk);
    n_cmp++;
    if (out_vec() !== RESET_VEC) begin
      n_err++;
      $display("FAIL reset_dropped: got %h, required %h", out_vec(), RESET_VEC);
    end
  endtask

  task automatic test_write16();
    int a;
    drive_req(1'b0, 4'h3, 2'b11, 16'hA55A, 1'b0, a);
    wait_drain();
    n_cmp++;
    if (last_rsp !== a + 1 + 2 * BYTE_CYC) begin
      n_err++;
      $display("FAIL write16_rsp_cycle: got %0d, required %0d", last_rsp, a + 1 + 2 * BYTE_CYC);
    end
  endtask

  task automatic test_read16();
    int a;
    model_even = 8'h12;
    model_odd  = 8'h34;
    drive_req(1'b1, 4'h5, 2'b11, 16'hFFFF, 1'b0, a);
    wait_drain();
    n_cmp++;
    if (hif.rsp_data_o !== 16'h1234) begin
      n_err++;
      $display("FAIL read16_hold: got %h, required 1234", hif.rsp_data_o);
    end
  endtask

  task automatic test_odd_read();
    int a;
    int f0 = n_falls;
    model_even = 8'h99;
    model_odd  = 8'hC7;
    drive_req(1'b1, 4'hA, 2'b01, 16'h0000, 1'b0, a);
    wait_drain();
    n_cmp++;
    if (n_falls - f0 !== 1) begin
      n_err++;
      $display("FAIL odd_read_strobes: got %0d, required 1", n_falls - f0);
    end
  endtask

  task automatic test_back_to_back();
    int a1, a2, f0;
    drive_req(1'b0, 4'h1, 2'b11, 16'hBEEF, 1'b1, a1);
    drive_req(1'b0, 4'h2, 2'b11, 16'hC0DE, 1'b0, a2);
    n_cmp++;
    if (a2 !== a1 + 1 + 2 * BYTE_CYC) begin
      n_err++;
      $display("FAIL b2b_accept: got cyc %0d, required %0d", a2, a1 + 1 + 2 * BYTE_CYC);
    end
    wait_drain();

    f0 = n_falls;
    drive_req(1'b0, 4'h4, 2'b00, 16'h1111, 1'b1, a1);
    drive_req(1'b1, 4'h6, 2'b00, 16'h2222, 1'b0, a2);
    n_cmp++;
    if (a2 !== a1 + 1) begin
      n_err++;
      $display("FAIL b2b_nobytes_accept: got cyc %0d, required %0d", a2, a1 + 1);
    end
    wait_drain();
    n_cmp++;
    if (n_falls !== f0) begin
      n_err++;
      $display("FAIL nobytes_cs: got %0d strobes, required 0", n_falls - f0);
    end
    n_cmp++;
    if (last_rsp !== a2 + 1) begin
      n_err++;
      $display("FAIL nobytes_rsp_cycle: got %0d, required %0d", last_rsp, a2 + 1);
    end
  endtask

  task automatic test_intr();
    for (int p = 0; p < 2; p++) begin
      @(posedge clk); #1;
      bus_intr_i = 1'b1;
      iq.push_back(cyc + 3);
      repeat (10) @(posedge clk);
      #1 bus_intr_i = 1'b0;
      repeat (6) @(posedge clk);
    end
    repeat (4) @(negedge clk);
    n_cmp++;
    if (iq.size() !== 0) begin
      n_err++;
      $display("FAIL intr_missing: %0d pulses outstanding, required 0", iq.size());
    end
  endtask

  initial begin
    hif.req_valid_i   = 1'b0;
    hif.req_rd_nwr_i  = 1'b0;
    hif.req_reg_num_i = 4'h0;
    hif.req_bytes_i   = 2'b00;
    hif.req_data_i    = 16'h0000;

    test_reset();
    test_write16();
    test_read16();
    test_odd_read();
    test_back_to_back();
    test_intr();

    n_cmp++;
    if (rq.size() !== 0 || sq.size() !== 0) begin
      n_err++;
      $display("FAIL final_queues: %0d rsp / %0d strobes left, required 0", rq.size(), sq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/xosera_host_bus.md
# xosera_host_bus

Host-side bus initiator for the Xosera 8-bit register bus. It turns a 16-bit register read/write request into one or two byte strobes on `bus_cs_n`, `bus_rd_nwr`, `bus_reg_num`, `bus_bytesel` and `bus_data`, then returns read data. It also synchronises `bus_intr` into a one-cycle host interrupt pulse. It sits in the FPGA host/bring-up shell (soft CPU or test sequencer) and drives the `xosera_main` bus inputs directly.

## Interface
Parameters:
- `SETUP_CYCLES`, default 1: cycles address/control are valid with CS high before the strobe (range 1..15).
- `STROBE_CYCLES`, default 2: cycles CS is held low per byte (range 1..15).
- `HOLD_CYCLES`, default 1: cycles CS is high after the strobe with address/data held (range 1..15).

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `reset_n_i` in 1: asynchronous, active-low reset.
- `req_valid_i` in 1: request valid.
- `req_ready_o` out 1: block is idle; a request is accepted on `req_valid_i & req_ready_o`.
- `req_rd_nwr_i` in 1: 1 = read, 0 = write.
- `req_reg_num_i` in 4: register number.
- `req_bytes_i` in 2: byte enables; [1] = even/upper byte, [0] = odd/lower byte.
- `req_data_i` in 16: write data; [15:8] is the even byte.
- `rsp_valid_o` out 1: one-cycle completion pulse, issued for reads and writes.
- `rsp_data_o` out 16: read data, valid while `rsp_valid_o` is high.
- `bus_cs_n_o` out 1: chip select, active low.
- `bus_rd_nwr_o` out 1: 1 = read, 0 = write.
- `bus_reg_num_o` out 4: register number.
- `bus_bytesel_o` out 1: 0 = even byte, 1 = odd byte.
- `bus_data_o` out 8: write data.
- `bus_data_oe_o` out 1: host data driver enable.
- `bus_data_i` in 8: read data from Xosera.
- `bus_intr_i` in 1: Xosera interrupt.
- `intr_o` out 1: one-cycle interrupt pulse.

## Operation
- **Reset values** (applied asynchronously, all outputs registered):
  - `bus_cs_n_o`=1, `bus_rd_nwr_o`=1, `bus_reg_num_o`=0, `bus_bytesel_o`=0, `bus_data_o`=0, `bus_data_oe_o`=0
  - `rsp_valid_o`=0, `rsp_data_o`=0, `intr_o`=0, `req_ready_o`=1 (IDLE)
- **FSM states:** IDLE, SETUP, STROBE, HOLD. A single 4-bit down-counter times each phase.
- **Accept:** capture rd_nwr, reg_num, bytes, data. Clear the read accumulator. Go to SETUP on the first enabled byte; the even byte is always first.
- **SETUP:**
  - drive reg_num, rd_nwr and bytesel; CS stays high
  - on a write, drive `bus_data_o` with the byte and set `bus_data_oe_o`=1
  - after SETUP_CYCLES go to STROBE
- **STROBE:**
  - `bus_cs_n_o`=0 for STROBE_CYCLES
  - on a read, sample `bus_data_i` on the clock edge ending the last strobe cycle, into [15:8] (even) or [7:0] (odd)
- **HOLD:**
  - CS high; address, data and OE held for HOLD_CYCLES
  - then go to SETUP for the odd byte if enabled and not yet done; otherwise go to IDLE with `rsp_valid_o`=1 and `bus_data_oe_o`=0
- **Byte order:** even before odd, always. Xosera commits a 16-bit write on the odd byte.
- **Disabled bytes** read as 0x00 in `rsp_data_o`.
- **`req_bytes_i`=00:** no bus activity. `rsp_valid_o` pulses the cycle after accept with data 0.
- **`rsp_data_o`** holds its value until the next response.
- **Back-to-back requests:** `req_ready_o`=1 in the same cycle as `rsp_valid_o`, so a new request may be accepted then. Its SETUP follows immediately, so bus CS-high time is at least HOLD+SETUP.
- **Interrupt path:**
  - `bus_intr_i` passes through a 2-flop synchroniser
  - `intr_o` pulses for one cycle on a rising edge of the synchronised level
  - a level held high gives a single pulse
- **Reset mid-transaction:** CS deasserts immediately. The transaction is dropped and no `rsp_valid_o` is issued.

## Timing
- Accept at cycle T. Each byte then takes SETUP_CYCLES + STROBE_CYCLES + HOLD_CYCLES cycles.
- `rsp_valid_o` at T + 1 + nbytes × (S + W + H).
- With defaults (1/2/1):
  - 16-bit access: rsp at T+9; CS low T+2..T+3 and T+6..T+7
  - single byte: rsp at T+5
- Read sample edge: end of cycle T+1+S+W−1 for the first byte.
- Interrupt latency: `intr_o` 3 cycles after the `bus_intr_i` rise (2 sync flops + edge register).
- `req_*` inputs need only be valid in the accept cycle.

## Structure
- Add to package `xv`:
  - `hb_state_t` enum: IDLE, SETUP, STROBE, HOLD
  - byte-enable constants `HB_EVEN`=2'b10, `HB_ODD`=2'b01
- One sub-module, `intr_sync`: 2-flop synchroniser plus rising-edge pulse, async active-low reset.
- Everything else (FSM, counter, capture registers) lives in `xosera_host_bus`.

## Test plan
- **Reset:** `reset_n_i`=0 asserted mid-strobe.
  - Expect `bus_cs_n_o`=1 with no clock edge.
  - Expect all outputs at reset values and no `rsp_valid_o`.
- **16-bit write:** reg 0x3, data 0xA55A, bytes 11, defaults.
  - Expect CS low T+2..T+3 with bytesel=0 and data 0xA5.
  - Expect CS low T+6..T+7 with bytesel=1 and data 0x5A.
  - Expect rsp at T+9.
- **16-bit read:** reg 0x5, model returns 0x12 (even) and 0x34 (odd).
  - Expect `bus_data_oe_o`=0 throughout.
  - Expect `rsp_data_o`=0x1234 at T+9.
- **Odd-only read** with bytes 01 and model byte 0xC7.
  - Expect a single strobe with bytesel=1.
  - Expect `rsp_data_o`=0x00C7 at T+5.
- **Back-to-back:** two writes with `req_valid_i` held high.
  - Expect the second accepted in the same cycle as the first rsp.
  - Expect ≥2 CS-high cycles between strobes.
  - Repeat with `req_bytes_i`=00: expect rsp at T+1 and no CS activity.
- **Interrupt:** `bus_intr_i` held high 10 cycles.
  - Expect exactly one `intr_o` pulse, 3 cycles after the rise.
  - A second rise after a low period gives a second pulse.
